rv32i_decode_exec_unit: RTL and testbench

Combinational RV32I instruction decoder, forwarding mux and ALU, bundled with one sticky status register, for the ID/EX stages of the 5-stage core. The core feeds the IF/ID instruction into the decoder. It feeds the ID/EX operands plus the EX/MEM and MEM/WB destination info into the forwarder. The ALU result drives branch resolution, JALR target and memory address.

---
 rtl/rv32i_decode_exec_unit_pkg.sv | 39 +++
 rtl/rv32i_alu_core.sv | 35 +++
 rtl/rv32i_decode_exec_unit.sv | 191 +++++++++++++++++++
 tb/tb_rv32i_decode_exec_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_decode_exec_unit_pkg.sv
// Shared encodings for the RV32I decode/execute slice: ALU ops, major opcodes, constants.
package rv32i_decode_exec_unit_pkg;

  typedef enum logic [3:0] {
    AluNone = 4'd0,
    AluAdd  = 4'd1,
    AluSub  = 4'd2,
    AluSll  = 4'd3,
    AluSlt  = 4'd4,
    AluSltu = 4'd5,
    AluXor  = 4'd6,
    AluSrl  = 4'd7,
    AluSra  = 4'd8,
    AluOr   = 4'd9,
    AluAnd  = 4'd10,
    AluEq   = 4'd11,
    AluNe   = 4'd12,
    AluGe   = 4'd13,
    AluGeu  = 4'd14
  } alu_op_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcFence  = 7'b0001111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic        TRUE  = 1'b1;
  localparam logic        FALSE = 1'b0;

endpackage

// File: rtl/rv32i_alu_core.sv
// Pure combinational RV32I ALU datapath; compare ops return 0/1.
module rv32i_alu_core
  import rv32i_decode_exec_unit_pkg::*;
(
  input  logic [3:0]  i_alu_op,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  output logic [31:0] o_result
);

  logic [4:0] w_shamt;
  assign w_shamt = i_src2[4:0];

  always_comb begin
    o_result = '0;
    case (i_alu_op)
      AluAdd:  o_result = i_src1 + i_src2;
      AluSub:  o_result = i_src1 - i_src2;
      AluSll:  o_result = i_src1 << w_shamt;
      AluSlt:  o_result = {31'd0, $signed(i_src1) < $signed(i_src2)};
      AluSltu: o_result = {31'd0, i_src1 < i_src2};
      AluXor:  o_result = i_src1 ^ i_src2;
      AluSrl:  o_result = i_src1 >> w_shamt;
      AluSra:  o_result = $unsigned($signed(i_src1) >>> w_shamt);
      AluOr:   o_result = i_src1 | i_src2;
      AluAnd:  o_result = i_src1 & i_src2;
      AluEq:   o_result = {31'd0, i_src1 == i_src2};
      AluNe:   o_result = {31'd0, i_src1 != i_src2};
      AluGe:   o_result = {31'd0, $signed(i_src1) >= $signed(i_src2)};
      AluGeu:  o_result = {31'd0, i_src1 >= i_src2};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_decode_exec_unit.sv
// RV32I ID decoder, EX operand forwarding and ALU, plus a sticky illegal-instruction flag.
module rv32i_decode_exec_unit
  import rv32i_decode_exec_unit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  output logic        o_jal,
  output logic        o_jalr,
  output logic        o_branch,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_alu_src,
  output logic        o_reg_write,
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic        o_illegal,
  output logic        o_illegal_seen,
  input  logic [4:0]  i_ex_rs1_addr,
  input  logic [4:0]  i_ex_rs2_addr,
  input  logic [31:0] i_ex_rs1_val,
  input  logic [31:0] i_ex_rs2_val,
  input  logic [3:0]  i_ex_alu_op,
  input  logic        i_ex_alu_src,
  input  logic [31:0] i_ex_imm,
  input  logic        i_mem_reg_write,
  input  logic [4:0]  i_mem_rd_addr,
  input  logic [31:0] i_mem_rd_val,
  input  logic [4:0]  i_wb_rd_addr,
  input  logic [31:0] i_wb_rd_val,
  output logic [31:0] o_rs1_fwd,
  output logic [31:0] o_rs2_fwd,
  output logic [31:0] o_alu_result
);

  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_jal, w_jalr, w_branch, w_mem_read, w_mem_write, w_alu_src, w_reg_write;
  logic        w_illegal, w_use_rs1, w_use_rs2, w_rw_final;
  alu_op_e     w_alu_op;
  logic [31:0] w_imm, w_src2;
  logic        r_illegal_seen;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'd0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};

  always_comb begin
    w_jal = FALSE; w_jalr = FALSE; w_branch = FALSE; w_mem_read = FALSE;
    w_mem_write = FALSE; w_alu_src = FALSE; w_reg_write = FALSE;
    w_illegal = FALSE; w_use_rs1 = FALSE; w_use_rs2 = FALSE;
    w_alu_op = AluNone;
    w_imm = '0;
    case (w_opc)
      OpcOp: begin
        w_reg_write = TRUE; w_use_rs1 = TRUE; w_use_rs2 = TRUE;
        case (w_f3)
          3'b000:  w_alu_op = (w_f7 == F7Alt) ? AluSub : AluAdd;
          3'b001:  w_alu_op = AluSll;
          3'b010:  w_alu_op = AluSlt;
          3'b011:  w_alu_op = AluSltu;
          3'b100:  w_alu_op = AluXor;
          3'b101:  w_alu_op = (w_f7 == F7Alt) ? AluSra : AluSrl;
          3'b110:  w_alu_op = AluOr;
          default: w_alu_op = AluAnd;
        endcase
        if (!(w_f7 == F7Base || (w_f7 == F7Alt && (w_f3 == 3'b000 || w_f3 == 3'b101))))
          w_illegal = TRUE;
      end
      OpcOpImm: begin
        w_reg_write = TRUE; w_alu_src = TRUE; w_use_rs1 = TRUE; w_imm = w_imm_i;
        case (w_f3)
          3'b000:  w_alu_op = AluAdd;
          3'b001:  w_alu_op = AluSll;
          3'b010:  w_alu_op = AluSlt;
          3'b011:  w_alu_op = AluSltu;
          3'b100:  w_alu_op = AluXor;
          3'b101:  w_alu_op = (w_f7 == F7Alt) ? AluSra : AluSrl;
          3'b110:  w_alu_op = AluOr;
          default: w_alu_op = AluAnd;
        endcase
        if ((w_f3 == 3'b001 && w_f7 != F7Base) ||
            (w_f3 == 3'b101 && w_f7 != F7Base && w_f7 != F7Alt))
          w_illegal = TRUE;
      end
      OpcLoad: begin
        w_mem_read = TRUE; w_reg_write = TRUE; w_alu_src = TRUE; w_use_rs1 = TRUE;
        w_alu_op = AluAdd; w_imm = w_imm_i;
        w_illegal = (w_f3 != 3'b010);
      end
      OpcStore: begin
        w_mem_write = TRUE; w_alu_src = TRUE; w_use_rs1 = TRUE; w_use_rs2 = TRUE;
        w_alu_op = AluAdd; w_imm = w_imm_s;
        w_illegal = (w_f3 != 3'b010);
      end
      OpcBranch: begin
        w_branch = TRUE; w_use_rs1 = TRUE; w_use_rs2 = TRUE; w_imm = w_imm_b;
        case (w_f3)
          3'b000:  w_alu_op = AluEq;
          3'b001:  w_alu_op = AluNe;
          3'b100:  w_alu_op = AluSlt;
          3'b101:  w_alu_op = AluGe;
          3'b110:  w_alu_op = AluSltu;
          3'b111:  w_alu_op = AluGeu;
          default: w_illegal = TRUE;
        endcase
      end
      OpcJal: begin
        w_jal = TRUE; w_reg_write = TRUE; w_imm = w_imm_j;
      end
      OpcJalr: begin
        w_jalr = TRUE; w_reg_write = TRUE; w_alu_src = TRUE; w_use_rs1 = TRUE;
        w_alu_op = AluAdd; w_imm = w_imm_i;
        w_illegal = (w_f3 != 3'b000);
      end
      OpcLui: begin
        w_reg_write = TRUE; w_alu_src = TRUE; w_alu_op = AluAdd; w_imm = w_imm_u;
      end
      OpcFence: ;
      default: w_illegal = TRUE;
    endcase
    // An illegal instruction must look exactly like a bubble downstream.
    if (w_illegal) begin
      w_jal = FALSE; w_jalr = FALSE; w_branch = FALSE; w_mem_read = FALSE;
      w_mem_write = FALSE; w_alu_src = FALSE; w_reg_write = FALSE;
      w_use_rs1 = FALSE; w_use_rs2 = FALSE;
      w_alu_op = AluNone; w_imm = '0;
    end
  end

  assign w_rw_final  = w_reg_write && (i_instr[11:7] != 5'd0);
  assign o_jal       = w_jal;
  assign o_jalr      = w_jalr;
  assign o_branch    = w_branch;
  assign o_mem_read  = w_mem_read;
  assign o_mem_write = w_mem_write;
  assign o_alu_src   = w_alu_src;
  assign o_reg_write = w_rw_final;
  assign o_alu_op    = w_alu_op;
  assign o_imm       = w_imm;
  assign o_illegal   = w_illegal;
  assign o_rs1_addr  = w_use_rs1 ? i_instr[19:15] : 5'd0;
  assign o_rs2_addr  = w_use_rs2 ? i_instr[24:20] : 5'd0;
  assign o_rd_addr   = w_rw_final ? i_instr[11:7] : 5'd0;

  // MEM beats WB; x0 never matches.
  always_comb begin
    o_rs1_fwd = i_ex_rs1_val;
    if (i_mem_reg_write && i_mem_rd_addr != 5'd0 && i_mem_rd_addr == i_ex_rs1_addr)
      o_rs1_fwd = i_mem_rd_val;
    else if (i_wb_rd_addr != 5'd0 && i_wb_rd_addr == i_ex_rs1_addr)
      o_rs1_fwd = i_wb_rd_val;
  end

  always_comb begin
    o_rs2_fwd = i_ex_rs2_val;
    if (i_mem_reg_write && i_mem_rd_addr != 5'd0 && i_mem_rd_addr == i_ex_rs2_addr)
      o_rs2_fwd = i_mem_rd_val;
    else if (i_wb_rd_addr != 5'd0 && i_wb_rd_addr == i_ex_rs2_addr)
      o_rs2_fwd = i_wb_rd_val;
  end

  assign w_src2 = i_ex_alu_src ? i_ex_imm : o_rs2_fwd;

  rv32i_alu_core u_alu (
    .i_alu_op (i_ex_alu_op),
    .i_src1   (o_rs1_fwd),
    .i_src2   (w_src2),
    .o_result (o_alu_result)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_illegal_seen <= 1'b0;
    else if (w_illegal) r_illegal_seen <= 1'b1;
  end

  assign o_illegal_seen = r_illegal_seen;

endmodule

// File: tb/tb_rv32i_decode_exec_unit.sv
// Scoreboard bench: stimulus queues expected values, a negedge monitor pops and compares.
module tb_rv32i_decode_exec_unit;

  localparam int FCtrl = 0, FAluOp = 1, FImm = 2, FRs1A = 3, FRs2A = 4, FRdA = 5;
  localparam int FRs1F = 6, FRs2F = 7, FRes = 8, FSeen = 9;

  typedef struct {
    int          field;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = 32'h0000_0013;
  logic        jal, jalr, branch, mem_read, mem_write, alu_src, reg_write, illegal, seen;
  logic [3:0]  alu_op;
  logic [31:0] imm, rs1_fwd, rs2_fwd, alu_result;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [4:0]  ex_rs1_addr = '0, ex_rs2_addr = '0, mem_rd_addr = '0, wb_rd_addr = '0;
  logic [31:0] ex_rs1_val = '0, ex_rs2_val = '0, ex_imm = '0, mem_rd_val = '0, wb_rd_val = '0;
  logic [3:0]  ex_alu_op = '0;
  logic        ex_alu_src = 1'b0, mem_reg_write = 1'b0;

  exp_t q[$];
  int   n_checks = 0, n_pass = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  rv32i_decode_exec_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr),
    .o_jal(jal), .o_jalr(jalr), .o_branch(branch), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_alu_src(alu_src), .o_reg_write(reg_write),
    .o_alu_op(alu_op), .o_imm(imm), .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr),
    .o_rd_addr(rd_addr), .o_illegal(illegal), .o_illegal_seen(seen),
    .i_ex_rs1_addr(ex_rs1_addr), .i_ex_rs2_addr(ex_rs2_addr),
    .i_ex_rs1_val(ex_rs1_val), .i_ex_rs2_val(ex_rs2_val),
    .i_ex_alu_op(ex_alu_op), .i_ex_alu_src(ex_alu_src), .i_ex_imm(ex_imm),
    .i_mem_reg_write(mem_reg_write), .i_mem_rd_addr(mem_rd_addr), .i_mem_rd_val(mem_rd_val),
    .i_wb_rd_addr(wb_rd_addr), .i_wb_rd_val(wb_rd_val),
    .o_rs1_fwd(rs1_fwd), .o_rs2_fwd(rs2_fwd), .o_alu_result(alu_result)
  );

  task automatic expect_val(input int field, input logic [31:0] exp, input string name);
    exp_t e;
    e.field = field; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  // Ctrl word is {jal,jalr,branch,mem_read,mem_write,alu_src,reg_write,illegal}.
  task automatic expect_dec(input string nm, input logic [7:0] ctrl, input logic [3:0] op,
                            input logic [31:0] im, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [4:0] ad);
    expect_val(FCtrl, {24'd0, ctrl}, {nm, ".ctrl"});
    expect_val(FAluOp, {28'd0, op}, {nm, ".alu_op"});
    expect_val(FImm, im, {nm, ".imm"});
    expect_val(FRs1A, {27'd0, a1}, {nm, ".rs1_addr"});
    expect_val(FRs2A, {27'd0, a2}, {nm, ".rs2_addr"});
    expect_val(FRdA, {27'd0, ad}, {nm, ".rd_addr"});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [31:0] a, input logic [31:0] b, input logic src,
                         input logic [31:0] im, input logic [3:0] op);
    mem_reg_write = 1'b0; mem_rd_addr = '0; wb_rd_addr = '0;
    ex_rs1_addr = 5'd1; ex_rs2_addr = 5'd2;
    ex_rs1_val = a; ex_rs2_val = b; ex_alu_src = src; ex_imm = im; ex_alu_op = op;
  endtask

  // Monitor: outputs are combinational, so every queued expectation is due at the next negedge.
  initial begin : monitor
    logic [31:0] act;
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.field)
          FCtrl:  act = {24'd0, jal, jalr, branch, mem_read, mem_write, alu_src, reg_write,
                         illegal};
          FAluOp: act = {28'd0, alu_op};
          FImm:   act = imm;
          FRs1A:  act = {27'd0, rs1_addr};
          FRs2A:  act = {27'd0, rs2_addr};
          FRdA:   act = {27'd0, rd_addr};
          FRs1F:  act = rs1_fwd;
          FRs2F:  act = rs2_fwd;
          FRes:   act = alu_result;
          default: act = {31'd0, seen};
        endcase
        n_checks++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  initial begin : stimulus
    #1;
    expect_val(FSeen, 32'd0, "reset.seen");
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    instr = 32'hFFF0_0293;  // addi x5,x0,-1
    expect_dec("addi", 8'h06, 4'd1, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd5);
    expect_val(FSeen, 32'd0, "addi.seen");
    next_cycle();
    instr = 32'h0061_2423;  // sw x6,8(x2)
    expect_dec("sw", 8'h0C, 4'd1, 32'd8, 5'd2, 5'd6, 5'd0);
    next_cycle();
    instr = 32'h0020_C463;  // blt x1,x2,8
    expect_dec("blt", 8'h20, 4'd4, 32'd8, 5'd1, 5'd2, 5'd0);
    next_cycle();
    instr = 32'h4031_00B3;  // sub x1,x2,x3
    expect_dec("sub", 8'h02, 4'd2, 32'd0, 5'd2, 5'd3, 5'd1);
    next_cycle();
    instr = 32'h0000_0013;  // nop: rd=0 suppresses the write
    expect_dec("nop", 8'h04, 4'd1, 32'd0, 5'd0, 5'd0, 5'd0);
    next_cycle();
    instr = 32'h1234_50B7;  // lui x1,0x12345 (rs1 field nonzero but forced to 0)
    expect_dec("lui", 8'h06, 4'd1, 32'h1234_5000, 5'd0, 5'd0, 5'd1);
    next_cycle();
    instr = 32'h0080_00EF;  // jal x1,8
    expect_dec("jal", 8'h82, 4'd0, 32'd8, 5'd0, 5'd0, 5'd1);
    next_cycle();
    instr = 32'h0200_0033;  // funct7 0000001 on OP is unsupported
    expect_dec("op_f7", 8'h01, 4'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    next_cycle();
    instr = 32'h0000_0013;
    expect_val(FSeen, 32'd1, "op_f7.seen");

    // Forwarding and ALU with a legal instruction in ID.
    ex_rs1_addr = 5'd5; ex_rs1_val = 32'h11; ex_rs2_addr = 5'd3; ex_rs2_val = 32'h22;
    mem_reg_write = 1'b1; mem_rd_addr = 5'd5; mem_rd_val = 32'd7;
    wb_rd_addr = 5'd5; wb_rd_val = 32'd9; ex_alu_op = 4'd1; ex_alu_src = 1'b0;
    expect_val(FRs1F, 32'd7, "fwd.mem_priority");
    expect_val(FRs2F, 32'h22, "fwd.rs2_nomatch");
    next_cycle();
    mem_reg_write = 1'b0;
    expect_val(FRs1F, 32'd9, "fwd.wb");
    next_cycle();
    mem_reg_write = 1'b1; wb_rd_addr = 5'd3;
    expect_val(FRs1F, 32'd7, "fwd.split_rs1");
    expect_val(FRs2F, 32'd9, "fwd.split_rs2");
    expect_val(FRes, 32'd16, "alu.add_fwd");
    next_cycle();
    mem_rd_addr = 5'd0; wb_rd_addr = 5'd0; ex_rs1_addr = 5'd0; ex_rs2_addr = 5'd0;
    expect_val(FRs1F, 32'h11, "fwd.x0_rs1");
    expect_val(FRs2F, 32'h22, "fwd.x0_rs2");
    next_cycle();

    set_alu(32'h8000_0000, 32'h0, 1'b1, 32'd4, 4'd8);
    expect_val(FRes, 32'hF800_0000, "alu.sra");
    next_cycle();
    set_alu(32'h1, 32'h0, 1'b1, 32'hFFFF_FFFF, 4'd5);
    expect_val(FRes, 32'd1, "alu.sltu");
    next_cycle();
    set_alu(32'h1, 32'h0, 1'b1, 32'hFFFF_FFFF, 4'd4);
    expect_val(FRes, 32'd0, "alu.slt");
    next_cycle();
    set_alu(32'hFFFF_FFFE, 32'd3, 1'b0, 32'h0, 4'd4);
    expect_val(FRes, 32'd1, "alu.blt");
    next_cycle();
    set_alu(32'h0, 32'd1, 1'b0, 32'h0, 4'd2);
    expect_val(FRes, 32'hFFFF_FFFF, "alu.sub_wrap");
    next_cycle();
    set_alu(32'h1234, 32'h1234, 1'b0, 32'h0, 4'd15);
    expect_val(FRes, 32'd0, "alu.code15");
    next_cycle();

    // Sticky flag: clear by reset, then set by the all-zero instruction.
    rst_n = 1'b0;
    expect_val(FSeen, 32'd0, "rst2.seen");
    next_cycle();
    rst_n = 1'b1;
    instr = 32'h0000_0000;
    expect_dec("zero", 8'h01, 4'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    expect_val(FSeen, 32'd0, "zero.seen_before_edge");
    next_cycle();
    instr = 32'hFFF0_0293;
    expect_val(FSeen, 32'd1, "zero.seen_after_edge");
    expect_val(FCtrl, 32'h06, "after_zero.ctrl");
    next_cycle();
    rst_n = 1'b0;
    #1;
    if (seen !== 1'b0) $display("FAIL async_reset.seen: got %0b expected 0", seen);
    else n_pass++;
    n_checks++;
    expect_val(FSeen, 32'd0, "reset_low.seen");
    next_cycle();
    next_cycle();
    stim_done = 1'b1;
  end

  initial begin : finisher
    fork
      wait (stim_done);
      #20000;
    join_any
    if (!stim_done) begin
      n_checks++;
      $display("FAIL timeout: stimulus incomplete, got 0 expected 1");
    end
    #20;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
